// File: rtl/adder_share_arbiter_if.sv
// ============================================================================
// Module   : adder_share_arbiter_if
// Purpose  : Request/response bundle for the shared-adder arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface adder_share_arbiter_if #(
  parameter int BIT_WIDTH = 8,
  parameter int N_REQ     = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*BIT_WIDTH-1:0] req_a;
  logic [N_REQ*BIT_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [BIT_WIDTH-1:0]       rsp_sum;
  logic [ID_W-1:0]            rsp_id;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Round-robin sharing of one registered adder among N_REQ
//            requesters; optional saturation via ADD_SHARE_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_share_arbiter #(
  parameter int BIT_WIDTH = 8,
  parameter int N_REQ     = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  adder_share_arbiter_if.slave bus
);

  localparam int              ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W:0]   N_REQ_X = (ID_W+1)'(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BIT_WIDTH-1:0] a_q, a_d;
  logic [BIT_WIDTH-1:0] b_q, b_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BIT_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;

  logic [N_REQ-1:0]     valid_rot;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_off;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      ptr_next;
  logic                 accept;
  logic                 rsp_fire;
  logic [BIT_WIDTH-1:0] sum_res;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  assign valid_rot = (bus.req_valid >> rr_ptr_q)
                   | (bus.req_valid << (N_REQ_X - {1'b0, rr_ptr_q}));

  always_comb begin
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_any = 1'b1;
        grant_off = ID_W'(k);
      end
    end
  end

  assign grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
  assign grant_idx = (grant_sum >= N_REQ_X) ? ID_W'(grant_sum - N_REQ_X)
                                            : grant_sum[ID_W-1:0];
  assign ptr_next  = ({1'b0, grant_idx} == (N_REQ_X - 1'b1)) ? '0
                                                              : grant_idx + 1'b1;

  assign accept   = (state_q == S_IDLE) && grant_any;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

`ifdef ADD_SHARE_SAT_EN
  logic [BIT_WIDTH:0] sum_full;
  assign sum_full = {1'b0, a_q} + {1'b0, b_q};
  assign sum_res  = sum_full[BIT_WIDTH] ? {BIT_WIDTH{1'b1}} : sum_full[BIT_WIDTH-1:0];
`else
  assign sum_res  = a_q + b_q;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)   state_d = S_EXEC;
      S_EXEC:                state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // FSM outputs; grant is withheld while reset is asserted
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && accept) begin
      bus.req_ready = N_REQ'(1) << grant_idx;
    end
    bus.busy = (state_q != S_IDLE);
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      a_d      = bus.req_a[grant_idx*BIT_WIDTH +: BIT_WIDTH];
      b_d      = bus.req_b[grant_idx*BIT_WIDTH +: BIT_WIDTH];
      id_d     = grant_idx;
      rr_ptr_d = ptr_next;
    end
    if (state_q == S_EXEC) begin
      rsp_sum_d   = sum_res;
      rsp_id_d    = id_q;
      rsp_valid_d = 1'b1;
    end
    if ((state_q == S_RESP) && rsp_fire) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// Module   : tb_adder_share_arbiter
// Purpose  : Randomised scoreboard bench for adder_share_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;
  localparam int BW = 8;
  localparam int NR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.BIT_WIDTH(BW), .N_REQ(NR)) bus ();
  adder_share_arbiter #(.BIT_WIDTH(BW), .N_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int sum; int id; } exp_t;
  exp_t q[$];

  bit [NR-1:0] pend;
  int opa[NR];
  int opb[NR];
  int mptr, mphase;
  int req_pct, rdy_pct;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_sum(input int a, input int b);
    int s;
    s = a + b;
`ifdef ADD_SHARE_SAT_EN
    if (s > 255) s = 255;
`else
    s = s % 256;
`endif
    return s;
  endfunction

  function automatic int pick(input bit [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic apply();
    bus.req_valid = pend;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*BW +: BW] = BW'(opa[i]);
      bus.req_b[i*BW +: BW] = BW'(opb[i]);
    end
  endtask

  task automatic cycle();
    int g;
    @(negedge clk);
    g = (mphase == 0) ? pick(pend, mptr) : -1;
    check("req_ready", int'(bus.req_ready), (g < 0) ? 0 : (1 << g));
    check("busy", int'(bus.busy), int'(mphase != 0));
    check("rsp_valid_latency", int'(bus.rsp_valid), int'(mphase == 2));
    @(posedge clk);
    case (mphase)
      0: if (g >= 0) begin
           q.push_back('{ref_sum(opa[g], opb[g]), g});
           mptr = (g + 1) % NR;
           pend[g] = 1'b0;
           mphase = 1;
         end
      1: mphase = 2;
      default: if (bus.rsp_ready) mphase = 0;
    endcase
    #1;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && ($urandom_range(99) < req_pct)) begin
        pend[i] = 1'b1;
        opa[i]  = $urandom_range(255);
        opb[i]  = $urandom_range(255);
      end
    end
    bus.rsp_ready = ($urandom_range(99) < rdy_pct);
    apply();
  endtask

  task automatic drain();
    int n;
    req_pct = 0;
    rdy_pct = 100;
    n = 0;
    while ((pend != 0 || mphase != 0 || q.size() != 0) && n < 100) begin
      cycle();
      n++;
    end
    check("drain_done", int'(pend == 0 && mphase == 0 && q.size() == 0), 1);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  // Monitor: pops the scoreboard whenever a response is accepted
  bit stalled = 1'b0;
  int prev_sum, prev_id;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else if (bus.rsp_valid) begin
        if (stalled) begin
          check("hold_sum", int'(bus.rsp_sum), prev_sum);
          check("hold_id", int'(bus.rsp_id), prev_id);
        end
        if (bus.rsp_ready) begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("rsp_sum", int'(bus.rsp_sum), e.sum);
            check("rsp_id", int'(bus.rsp_id), e.id);
          end
        end else begin
          stalled  = 1'b1;
          prev_sum = int'(bus.rsp_sum);
          prev_id  = int'(bus.rsp_id);
        end
      end
    end
  end

  initial begin
    pend = '0;
    for (int i = 0; i < NR; i++) begin opa[i] = 0; opb[i] = 0; end
    mptr = 0; mphase = 0; req_pct = 0; rdy_pct = 100;
    bus.rsp_ready = 1'b0;
    apply();

    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_sum", int'(bus.rsp_sum), 0);
    check("rst_rsp_id", int'(bus.rsp_id), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_req_ready", int'(bus.req_ready), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // Lone requester 0: 3+5
    set_req(0, 3, 5); apply();
    for (int i = 0; i < 5; i++) cycle();
    drain();

    // All requesters held valid: strictly cyclic grants
    req_pct = 100; rdy_pct = 100;
    for (int i = 0; i < NR; i++) set_req(i, $urandom_range(255), $urandom_range(255));
    apply();
    for (int i = 0; i < 16; i++) cycle();
    drain();

    // Pointer set to 2 via a grant to 1, then 1010: expect 3 then wrap to 1
    set_req(1, 10, 20); apply();
    for (int i = 0; i < 4; i++) cycle();
    set_req(1, 7, 9); set_req(3, 250, 6); apply();
    drain();

    // Overflow case
    set_req(2, 200, 100); apply();
    drain();

    // Back-pressure with all requesters pending
    for (int i = 0; i < NR; i++) set_req(i, $urandom_range(255), $urandom_range(255));
    apply();
    rdy_pct = 0;
    for (int i = 0; i < 8; i++) cycle();
    drain();

    // Reset during EXEC discards the transaction
    set_req(2, 40, 50); apply();
    cycle();
    check("pre_reset_exec", mphase, 1);
    #2 rst_n = 1'b0;
    #1;
    q.delete(); mphase = 0; mptr = 0;
    check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    set_req(1, 11, 22); apply();
    #1 check("mid_rst_req_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    drain();

    // Randomised traffic
    req_pct = 30; rdy_pct = 60;
    for (int i = 0; i < 400; i++) cycle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
